// File: rtl/toggle_rx.sv
// toggle_rx: receiving end of a two-phase (toggle) handshake link.
// A level mismatch between synchronised req_t and ack_t is one pending word.
// The word is captured into a small first-word-fall-through buffer and
// acknowledged by inverting ack_t. The buffer drains through valid/ready.
//
// Ports:
//   clk      - rising-edge clock
//   clrn     - asynchronous active-low clear
//   req_t    - toggle request from the sender (asynchronous to clk)
//   data_in  - sender data, stable while a transfer is outstanding
//   ack_t    - toggle acknowledge back to the sender
//   valid    - buffer not empty
//   ready    - consumer accepts data_out when valid is high
//   data_out - oldest buffered word, 0 when empty
//   count    - buffer occupancy
module toggle_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     req_t,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     ack_t,
  output logic                     valid,
  input  logic                     ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic                   r_valid;
  logic [WIDTH-1:0]       r_data_out;

  logic                   w_req_s;
  logic                   w_pending;
  logic                   w_capture;
  logic                   w_pop;
  logic [CW-1:0]          w_count_nxt;
  logic [PW-1:0]          w_rd_ptr_nxt;
  logic [WIDTH-1:0]       w_data_nxt;

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_pending = w_req_s ^ r_ack;
  // Full check uses the registered count only; a same-edge pop does not free a slot.
  assign w_capture = w_pending && (r_count < CW'(DEPTH));
  assign w_pop     = r_valid && ready;

  // Next occupancy, read pointer and head word, so valid/data_out can be registered.
  always_comb begin
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    w_data_nxt   = '0;
    if (w_capture && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_capture) begin
      w_count_nxt = r_count - CW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end
    if (w_count_nxt != '0) begin
      // The new head is the word being written this edge when the buffer was
      // empty, or held one word that is popped at the same time.
      if (w_capture && (r_wr_ptr == w_rd_ptr_nxt)) begin
        w_data_nxt = data_in;
      end else begin
        w_data_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // req_t synchroniser.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_t};
    end
  end

  // Buffer control, acknowledge and registered consumer-side outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ack      <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_valid    <= 1'b0;
      r_data_out <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_ack    <= ~r_ack;
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_valid    <= (w_count_nxt != '0);
      r_data_out <= w_data_nxt;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_capture) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  assign ack_t    = r_ack;
  assign valid    = r_valid;
  assign data_out = r_data_out;
  assign count    = r_count;

endmodule

// File: doc/toggle_rx.md
Name: toggle_rx

Overview:
- Two-phase (toggle) handshake responder. It is the receiving end of a toggle-signalling link whose request line is driven by a toggle flip-flop in another clock domain.
- Each transition on req_t means one new data word. The block synchronises req_t, captures the word into a small first-word-fall-through buffer and answers by toggling ack_t.
- The buffer is presented to a local consumer with a valid/ready handshake.
- It sits between an asynchronous toggle-based sender and synchronous lab datapath logic.

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 2, buffer entries; legal values 2 or 4
- SYNC_STAGES, 2, flip-flops in the req_t synchroniser; minimum 2

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low clear; all state cleared while low
- req_t  input  1  toggle request from sender; every level change is one transfer; asynchronous to clk
- data_in  input  WIDTH  sender data; stable from before a req_t toggle until the matching ack_t toggle
- ack_t  output  1  toggle acknowledge back to sender
- valid  output  1  buffer not empty; data_out holds the oldest word
- ready  input  1  consumer accepts data_out when valid and ready at a rising clk edge
- data_out  output  WIDTH  oldest buffered word; 0 when empty
- count  output  $clog2(DEPTH)+1  buffer occupancy

Behaviour:
- Reset (clrn low, asynchronous):
  - synchroniser flops = 0, ack_t = 0, count = 0, valid = 0, data_out = 0, read/write pointers = 0.
  - On release, operation resumes at the next rising edge.
- Synchroniser:
  - req_s is req_t delayed through SYNC_STAGES flops clocked by clk.
  - Only req_s is used internally; raw req_t is never used.
- Pending condition: pending = req_s XOR ack_t. No edge detector is used; level mismatch is the request.
- Capture:
  - Occurs on an edge where pending = 1 and count < DEPTH. The count check uses the registered count, with no same-cycle pop bypass.
  - On that edge: data_in is written at the write pointer, the write pointer increments, and ack_t inverts, which clears pending.
- Pop: on an edge where valid = 1 and ready = 1, the read pointer increments.
- Count update:
  - count += capture − pop.
  - Capture and pop on the same edge leave count unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Output timing:
  - valid = (count != 0); data_out = buffer[read pointer] when valid, else 0.
  - Both are registered-state functions and stable for the whole cycle.
- Latency: a req_t toggle set up before edge 0 reaches req_s after edge SYNC_STAGES−1 and is captured at edge SYNC_STAGES. ack_t toggles and valid rises after that edge: SYNC_STAGES+1 edges total.
- Full buffer:
  - pending stays 1 and ack_t is held, so the sender is stalled.
  - Capture happens on the first edge after a pop has made count < DEPTH, i.e. one cycle after the pop edge. Nothing is dropped or overwritten.
- Empty buffer: ready is ignored; count never underflows.
- At most one transfer can be outstanding per the two-phase protocol. Pending cannot re-assert until the sender toggles req_t again.
- Reset mid-operation:
  - Buffered words are discarded and ack_t returns to 0.
  - If req_t = 1 when clrn releases, pending appears after synchronisation and exactly one capture follows. The sender must be reset together with this block.
- ready high while valid is low has no effect.

Test Plan:
- Reset: clrn low with req_t = 0 → ack_t = 0, valid = 0, count = 0, data_out = 0; release, idle 10 cycles → no change.
- Single transfer: data_in = 8'hA5, req_t 0→1, ready = 0 → after edge 2 (SYNC_STAGES = 2) ack_t = 1, valid = 1, data_out = 8'hA5, count = 1; pulse ready → valid = 0, count = 0.
- Back-to-back with ready = 0:
  - Send 8'h11 and 8'h22, each toggling req_t after the previous ack_t toggle → count = 2.
  - Send 8'h33 → ack_t holds at its current level and count stays 2.
  - Pop once → 8'h33 captured one cycle later, ack_t toggles, output order is 11, 22, 33.
- Simultaneous capture and pop: count = 1, pending arrives on the same edge that ready pops → count stays 1, data_out becomes the new word, ack_t toggles.
- Wrap-around: stream 10 words 8'h00..8'h09 with ready held high → all 10 received in order and pointers wrap; ack_t toggles exactly 10 times.
- Reset mid-operation: count = 2 and req_t = 1, assert clrn for 1 cycle → outputs zero. After release, exactly one capture occurs at edge 2 and ack_t = 1.
